// File: rtl/cursor_pkg.sv
// ============================================================================
// Module : cursor_pkg
// Brief  : Shared types and constants for the menu cursor overlay.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cursor_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [23:0] C_CURSOR_RGB = {8'd132, 8'd240, 8'd198};

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cursor_step.sv
// ============================================================================
// Module : cursor_step
// Brief  : Next grid position for one move, wrapping at every grid edge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cursor_step
  import cursor_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  parameter int unsigned RW   = 2,
  parameter int unsigned CW   = 2
) (
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  input  dir_t          i_dir,
  output logic [RW-1:0] o_next_row,
  output logic [CW-1:0] o_next_col
);

  localparam logic [RW-1:0] C_ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_COL_LAST = CW'(COLS - 1);

  always_comb begin
    o_next_row = i_row;
    o_next_col = i_col;
    case (i_dir)
      UP:      o_next_row = (i_row == '0)         ? C_ROW_LAST : i_row - 1'b1;
      DOWN:    o_next_row = (i_row == C_ROW_LAST) ? '0         : i_row + 1'b1;
      LEFT:    o_next_col = (i_col == '0)         ? C_COL_LAST : i_col - 1'b1;
      RIGHT:   o_next_col = (i_col == C_COL_LAST) ? '0         : i_col + 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cursor_controller.sv
// ============================================================================
// Module : cursor_controller
// Brief  : Grid-menu cursor bar overlay; moves commit on frame_start.
//          Optional blinking enabled by defining CURSOR_BLINK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cursor_controller
  import cursor_pkg::*;
#(
  parameter int unsigned COLS         = 3,
  parameter int unsigned ROWS         = 3,
  parameter int unsigned X0           = 73,
  parameter int unsigned Y0           = 126,
  parameter int unsigned CELL_W       = 210,
  parameter int unsigned CELL_H       = 158,
  parameter int unsigned BAR_W        = 65,
  parameter int unsigned BAR_H        = 3,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [23:0] CURSOR_RGB   = C_CURSOR_RGB
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [9:0]                         pixelx,
  input  logic [9:0]                         pixely,
  input  logic                               frame_start,
  input  logic                               move_valid,
  input  logic [1:0]                         move_dir,
  output logic                               move_ready,
  output logic [idx_width(ROWS*COLS)-1:0]    sel_position,
  output logic                               is_visible,
  output logic [23:0]                        RGB
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned CW = idx_width(COLS);
  localparam int unsigned SW = idx_width(ROWS * COLS);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_commit;

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_nrow;
  logic [CW-1:0] r_ncol;
  logic [RW-1:0] w_step_row;
  logic [CW-1:0] w_step_col;
  logic [SW-1:0] r_sel;

  logic [10:0]   w_x_lo;
  logic [10:0]   w_x_hi;
  logic [10:0]   w_y_lo;
  logic [10:0]   w_y_hi;
  logic          w_hit;
  logic          w_show;
  logic          r_visible;
  logic [23:0]   r_rgb;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A move taken while frame_start is high waits for the following frame.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (move_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign move_ready = (r_state == ST_IDLE);

  // ----------------------------------------------------------- position
  cursor_step #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_step (
    .i_row      (r_row),
    .i_col      (r_col),
    .i_dir      (dir_t'(move_dir)),
    .o_next_row (w_step_row),
    .o_next_col (w_step_col)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_nrow <= '0;
      r_ncol <= '0;
      r_sel  <= '0;
    end else begin
      if (w_accept) begin
        r_nrow <= w_step_row;
        r_ncol <= w_step_col;
      end
      if (w_commit) begin
        r_row <= r_nrow;
        r_col <= r_ncol;
        r_sel <= SW'(r_nrow * COLS + r_ncol);
      end
    end
  end

  assign sel_position = r_sel;

  // ---------------------------------------------------------- bar hit
  assign w_x_lo = 11'(X0 + r_col * CELL_W);
  assign w_x_hi = 11'(X0 + r_col * CELL_W + BAR_W - 1);
  assign w_y_lo = 11'(Y0 + r_row * CELL_H);
  assign w_y_hi = 11'(Y0 + r_row * CELL_H + BAR_H - 1);

  assign w_hit = ({1'b0, pixelx} >= w_x_lo) && ({1'b0, pixelx} <= w_x_hi) &&
                 ({1'b0, pixely} >= w_y_lo) && ({1'b0, pixely} <= w_y_hi);

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BW = idx_width(BLINK_FRAMES);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // A commit lands on frame_start and takes priority, restarting visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_commit) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (frame_start) begin
      if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_show = w_hit & r_phase;
`else
  assign w_show = w_hit;
`endif

  // ------------------------------------------------------------ output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_visible <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_visible <= w_show;
      r_rgb     <= w_show ? CURSOR_RGB : 24'd0;
    end
  end

  assign is_visible = r_visible;
  assign RGB        = r_rgb;

endmodule

`default_nettype wire

// File: doc/cursor_controller.md
CURSOR_CONTROLLER -- requirements
Module: cursor_controller

Interface
REQ-001 SHALL have parameter COLS, default 3, grid columns (>=1).
REQ-002 SHALL have parameter ROWS, default 3, grid rows (>=1).
REQ-003 SHALL have parameter X0, default 73, left pixel of bar in column 0.
REQ-004 SHALL have parameter Y0, default 126, top pixel of bar in row 0.
REQ-005 SHALL have parameter CELL_W, default 210, horizontal pitch between columns, in pixels.
REQ-006 SHALL have parameter CELL_H, default 158, vertical pitch between rows, in pixels.
REQ-007 SHALL have parameter BAR_W, default 65, bar width in pixels.
REQ-008 SHALL have parameter BAR_H, default 3, bar height in pixels.
REQ-009 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period (>=1).
REQ-010 SHALL have parameter CURSOR_RGB, default {8'd132,8'd240,8'd198}, bar colour.
REQ-011 SHALL have port clk, input, 1, pixel clock; single clock domain.
REQ-012 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-013 SHALL have port pixelx, input, 10, current pixel column.
REQ-014 SHALL have port pixely, input, 10, current pixel row.
REQ-015 SHALL have port frame_start, input, 1, one-cycle pulse once per frame, during blanking.
REQ-016 SHALL have port move_valid, input, 1, move request.
REQ-017 SHALL have port move_dir, input, 2, move direction: 0 up, 1 down, 2 left, 3 right.
REQ-018 SHALL have port move_ready, output, 1, high when a move can be accepted.
REQ-019 SHALL have port sel_position, output, $clog2(ROWS*COLS), displayed cell index, row*COLS+col.
REQ-020 SHALL have port is_visible, output, 1, high when the pixel lies on the cursor bar.
REQ-021 SHALL have port RGB, output, 24, CURSOR_RGB when is_visible, else 0.

Function
REQ-022 SHALL implement FSM IDLE/PENDING; move_ready = (state==IDLE).
REQ-023 SHALL accept a move on move_valid && move_ready and latch next_row/next_col; IDLE->PENDING.
REQ-024 SHALL ignore move_valid while PENDING; requests are not queued.
REQ-025 SHALL, in PENDING on frame_start, commit next_row/next_col to the displayed position, restart blink in visible phase, and return to IDLE.
REQ-026 SHALL commit a move accepted in the same cycle as frame_start at the next frame_start, not the current one.
REQ-027 SHALL wrap moves: right from col COLS-1 to col 0; left from col 0 to col COLS-1; down from row ROWS-1 to row 0; up from row 0 to row ROWS-1; the other coordinate is unchanged.
REQ-028 SHALL assert the bar hit when X0+col*CELL_W <= pixelx <= X0+col*CELL_W+BAR_W-1 and Y0+row*CELL_H <= pixely <= Y0+row*CELL_H+BAR_H-1, with the comparison computed in 11 bits with no overflow.
REQ-029 SHALL register is_visible and RGB: a one-cycle latency from pixelx/pixely.
REQ-030 SHALL update sel_position in the cycle after commit.
REQ-031 SHALL count frame_start pulses in a blink counter; at BLINK_FRAMES-1 the counter returns to 0 and toggles the phase; is_visible = bar hit && phase.

Reset
REQ-032 SHALL, on rst_n=0 at a clk edge, set state IDLE, row=col=0, sel_position=0, blink counter 0, phase visible, is_visible=0, RGB=0, move_ready=1 from the next cycle.
REQ-033 SHALL discard any pending move when reset is asserted in PENDING.

Configuration
REQ-034 SHALL, with CURSOR_BLINK_EN defined, blink per REQ-031.
REQ-035 SHALL, with CURSOR_BLINK_EN undefined, remove the blink counter and phase; is_visible = bar hit; BLINK_FRAMES unused.

Structure
REQ-036 SHALL place dir_t (UP/DOWN/LEFT/RIGHT enum) and the default colour constant in package cursor_pkg.
REQ-037 SHALL place wrap/next-position logic in sub-module cursor_step (inputs row, col, dir; outputs next row, next col).

Verification
REQ-038 Reset, pixel (73,126) -> next cycle is_visible=1, RGB=0x84F0C6; pixel (72,126) -> 0.
REQ-039 Move right (dir=3), then frame_start -> sel_position=1; bar hit at x=283..347, y=126..128 only.
REQ-040 At sel=2, move right -> sel=0; at sel=0, move up -> sel=6; at sel=8, move down -> sel=2.
REQ-041 Second move_valid while PENDING -> move_ready=0, ignored; one frame_start -> exactly one step.
REQ-042 With CURSOR_BLINK_EN defined and BLINK_FRAMES=2: over 4 frame_starts, phase pattern is on,on,off,off; after a commit, phase = on.
REQ-043 rst_n low during PENDING -> sel_position=0, move_ready=1; a later frame_start does not move the cursor.
